// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared pipeline defines for the instruction fetch queue
package fetch_queue_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fq_state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        misaligned;
   } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// rtl/fq_fifo.sv - parameterised FIFO storage with wrap-bit pointers and flush
module fq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 65
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   // Extra pointer bit makes the difference an exact occupancy, full included.
   assign count = wr_ptr - rd_ptr;
   assign valid = (count != '0);
   assign rdata = valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - credit-based instruction fetch queue with redirect and misaligned-PC halt
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] fetch_addr,
   output logic        fetch_valid,
   input  logic        fetch_ready,
   input  logic [31:0] fetch_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_misaligned,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   fq_state_t   state;
   fq_state_t   state_nxt;
   logic [31:0] fpc;
   logic        outstanding;
   logic [31:0] out_pc;
   logic [CW-1:0] count;
   logic        credit_ok;
   logic        mis_push;
   logic        accept;
   logic        push;
   logic        pop;
   fq_entry_t   wentry;
   fq_entry_t   head;

   // A granted request still owes a queue slot, so it counts against space.
   assign credit_ok = (count + CW'(outstanding)) < CW'(DEPTH);

   always_comb begin
      state_nxt   = state;
      fetch_valid = 1'b0;
      mis_push    = 1'b0;
      case (state)
         ST_RUN: begin
            if (rst && !redirect && credit_ok) begin
               if (fpc[1:0] == 2'b00) begin
                  fetch_valid = 1'b1;
               end else begin
                  mis_push  = 1'b1;
                  state_nxt = ST_HALT;
               end
            end
         end
         ST_HALT: begin
            state_nxt = ST_HALT;
         end
         default: state_nxt = ST_RUN;
      endcase
      if (redirect) state_nxt = ST_RUN;
   end

   assign fetch_addr = fpc;
   assign accept     = fetch_valid & fetch_ready;
   assign push       = !redirect && (outstanding || mis_push);
   assign pop        = inst_valid && inst_ready && !redirect;

   always_comb begin
      if (outstanding) begin
         wentry.inst       = fetch_rdata;
         wentry.pc         = out_pc;
         wentry.misaligned = 1'b0;
      end else begin
         wentry.inst       = NOP_INST;
         wentry.pc         = fpc;
         wentry.misaligned = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_RUN;
         fpc         <= RESET_PC;
         outstanding <= 1'b0;
         out_pc      <= '0;
      end else begin
         state <= state_nxt;
         // Clearing outstanding drops any response landing in the redirect cycle.
         if (redirect) begin
            fpc         <= redirect_pc;
            outstanding <= 1'b0;
         end else begin
            outstanding <= accept;
            if (accept) begin
               out_pc <= fpc;
               fpc    <= fpc + 32'd4;
            end
         end
      end
   end

   fq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fq_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect),
      .push  (push),
      .wdata (wentry),
      .pop   (pop),
      .rdata (head),
      .valid (inst_valid),
      .count (count)
   );

   assign inst            = head.inst;
   assign inst_pc         = head.pc;
   assign inst_misaligned = head.misaligned;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-level model
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] fetch_addr;
   logic        fetch_valid;
   logic        fetch_ready = 1'b0;
   logic [31:0] fetch_rdata = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_misaligned;
   logic        inst_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_addr      (fetch_addr),
      .fetch_valid     (fetch_valid),
      .fetch_ready     (fetch_ready),
      .fetch_rdata     (fetch_rdata),
      .inst_valid      (inst_valid),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_misaligned (inst_misaligned),
      .inst_ready      (inst_ready),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        mis;
   } ent_t;

   // Reference model: an in-order list of entries plus the next fetch PC.
   ent_t        mq[$];
   logic [31:0] m_fpc;
   bit          m_halt;
   bit          m_pend;
   logic [31:0] m_pend_pc;

   logic [31:0] popped_pc[$];
   logic [31:0] popped_inst[$];
   logic        popped_mis[$];
   int          n_acc;
   int          n_chk;
   int          n_pass;

   bit          c_fr;
   bit          c_ir;
   bit          c_rd;
   logic [31:0] c_rpc;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_popped(string name, int idx, logic [31:0] exp);
      if (idx < popped_pc.size()) chk(name, popped_pc[idx], exp);
      else begin
         n_chk++;
         $display("FAIL %s: only %0d pops seen, expected pc %h at index %0d", name, popped_pc.size(), exp, idx);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_fpc  = 32'h0;
      m_halt = 1'b0;
      m_pend = 1'b0;
   endtask

   task automatic step();
      bit exp_fv;
      bit acc;
      bit pop;
      int sz;
      @(negedge clk);
      fetch_ready = c_fr;
      inst_ready  = c_ir;
      redirect    = c_rd;
      redirect_pc = c_rpc;
      // Memory answers with the word address as data; garbage when nothing is owed.
      fetch_rdata = m_pend ? m_pend_pc : $urandom();
      #1;
      sz     = mq.size();
      exp_fv = !m_halt && (m_fpc[1:0] == 2'b00) && !redirect && (sz + int'(m_pend) < DEPTH);
      chk("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
      if (exp_fv) chk("fetch_addr", fetch_addr, m_fpc);
      chk("inst_valid", 32'(inst_valid), 32'(sz > 0));
      if (sz > 0) begin
         chk("inst", inst, mq[0].inst);
         chk("inst_pc", inst_pc, mq[0].pc);
         chk("inst_misaligned", 32'(inst_misaligned), 32'(mq[0].mis));
      end
      acc = exp_fv && fetch_ready;
      pop = (sz > 0) && inst_ready && !redirect;
      if (fetch_valid && fetch_ready) n_acc++;
      if (inst_valid && inst_ready && !redirect) begin
         popped_pc.push_back(inst_pc);
         popped_inst.push_back(inst);
         popped_mis.push_back(inst_misaligned);
      end
      @(posedge clk);
      if (redirect) begin
         mq.delete();
         m_fpc  = redirect_pc;
         m_halt = 1'b0;
         m_pend = 1'b0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (m_pend) mq.push_back('{fetch_rdata, m_pend_pc, 1'b0});
         else if (!m_halt && m_fpc[1:0] != 2'b00 && sz < DEPTH) begin
            mq.push_back('{32'h0000_0013, m_fpc, 1'b1});
            m_halt = 1'b1;
         end
         if (acc) begin
            m_pend    = 1'b1;
            m_pend_pc = m_fpc;
            m_fpc     = m_fpc + 32'd4;
         end else begin
            m_pend = 1'b0;
         end
      end
   endtask

   // Called just after a posedge; asserts reset mid-cycle to exercise the async path.
   task automatic do_reset();
      #2;
      rst         = 1'b0;
      redirect    = 1'b0;
      fetch_ready = 1'b0;
      inst_ready  = 1'b0;
      #1;
      chk("rst_inst_valid", 32'(inst_valid), 32'h0);
      chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_inst_mis", 32'(inst_misaligned), 32'h0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("first_fetch_addr", fetch_addr, 32'h0);
      chk("first_fetch_valid", 32'(fetch_valid), 32'h1);
      c_rd = 1'b0;
   endtask

   task automatic clear_log();
      popped_pc.delete();
      popped_inst.delete();
      popped_mis.delete();
      n_acc = 0;
   endtask

   initial begin
      int found;
      int cnt;
      n_chk = 0;
      n_pass = 0;
      c_fr = 1'b1; c_ir = 1'b1; c_rd = 1'b0; c_rpc = '0;

      // Streaming after reset: addr-as-data, one per cycle
      @(posedge clk);
      do_reset();
      clear_log();
      c_fr = 1'b1; c_ir = 1'b1;
      repeat (8) step();
      chk_popped("stream_pc0", 0, 32'h0);
      chk_popped("stream_pc1", 1, 32'h4);
      chk_popped("stream_pc2", 2, 32'h8);
      chk("stream_count", popped_pc.size(), 32'd6);
      if (popped_inst.size() > 2) chk("stream_inst2", popped_inst[2], 32'h8);

      // Stalled consumer: credit caps accepts at DEPTH
      do_reset();
      clear_log();
      c_fr = 1'b1; c_ir = 1'b0;
      repeat (10) step();
      chk("stall_accepts", n_acc, 32'd4);
      #1;
      chk("stall_fetch_valid", 32'(fetch_valid), 32'h0);
      chk("stall_inst_valid", 32'(inst_valid), 32'h1);
      c_ir = 1'b1;
      repeat (8) step();
      chk_popped("drain_pc0", 0, 32'h0);
      chk_popped("drain_pc1", 1, 32'h4);
      chk_popped("drain_pc2", 2, 32'h8);
      chk_popped("drain_pc3", 3, 32'hC);
      chk_popped("drain_pc4", 4, 32'h10);

      // Redirect while the 0x20 response is in flight
      do_reset();
      c_fr = 1'b1; c_ir = 1'b1;
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         step();
         if (m_pend && m_pend_pc == 32'h20) found = 1;
      end
      chk("reach_0x20", found, 32'd1);
      clear_log();
      c_rd = 1'b1; c_rpc = 32'h100;
      step();
      c_rd = 1'b0;
      repeat (6) step();
      chk_popped("redir_pc0", 0, 32'h100);
      cnt = 0;
      foreach (popped_pc[i]) if (popped_pc[i] == 32'h20) cnt++;
      chk("redir_no_0x20", cnt, 32'd0);

      // Misaligned redirect halts fetch until the next redirect
      c_rd = 1'b1; c_rpc = 32'h102;
      step();
      c_rd = 1'b0;
      clear_log();
      repeat (8) step();
      chk_popped("mis_pc", 0, 32'h102);
      if (popped_inst.size() > 0) chk("mis_inst", popped_inst[0], 32'h0000_0013);
      if (popped_mis.size() > 0) chk("mis_flag", 32'(popped_mis[0]), 32'h1);
      chk("mis_single_entry", popped_pc.size(), 32'd1);
      chk("mis_no_fetch", n_acc, 32'd0);
      c_rd = 1'b1; c_rpc = 32'h200;
      step();
      c_rd = 1'b0;
      clear_log();
      repeat (5) step();
      chk_popped("restart_pc", 0, 32'h200);
      if (popped_mis.size() > 0) chk("restart_mis", 32'(popped_mis[0]), 32'h0);

      // PC wrap at the top of the address space
      c_rd = 1'b1; c_rpc = 32'hFFFF_FFF8;
      step();
      c_rd = 1'b0;
      clear_log();
      repeat (6) step();
      chk_popped("wrap_pc0", 0, 32'hFFFF_FFF8);
      chk_popped("wrap_pc1", 1, 32'hFFFF_FFFC);
      chk_popped("wrap_pc2", 2, 32'h0000_0000);

      // Async reset with three entries queued
      c_fr = 1'b1; c_ir = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (mq.size() == 3) found = 1;
      end
      chk("reach_3_entries", found, 32'd1);
      do_reset();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         c_fr = ($urandom_range(0, 3) != 0);
         c_ir = ($urandom_range(0, 2) != 0);
         c_rd = ($urandom_range(0, 19) == 0);
         c_rpc = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 4) == 0) c_rpc[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 599) == 0) do_reset();
         else step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
